// File: rtl/shift_issue_buffer.sv
// shift_issue_buffer: reservation buffer for shift micro-ops; define SHIFT_BUFFER_POP_BYPASS_EN for same-cycle reuse of a popped slot when full
module shift_issue_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       dispat_push,
  input  logic [DW-1:0]              dispat_info,
  output logic                       buffer_full,
  output logic [$clog2(DEPTH):0]     buffer_count,
  input  logic                       shift_buffer_pop,
  input  logic [$clog2(DEPTH)-1:0]   shift_buffer_pop_index,
  output logic [DEPTH-1:0]           shift_buffer_malloc,
  output logic [DW*DEPTH-1:0]        shift_issue_info
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DEPTH-1:0] malloc_q, malloc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DW-1:0]    info_q [DEPTH];
  logic [AW-1:0]    free_idx, tgt;
  logic             pop_ok, push_ok;
  assign pop_ok = shift_buffer_pop & malloc_q[shift_buffer_pop_index];
`ifdef SHIFT_BUFFER_POP_BYPASS_EN
  assign buffer_full = (&malloc_q) & ~pop_ok;
  assign tgt         = (&malloc_q) ? shift_buffer_pop_index : free_idx;
`else
  assign buffer_full = &malloc_q;
  assign tgt         = free_idx;
`endif
  assign push_ok = dispat_push & ~buffer_full;
  // lowest-index free slot, scanning high to low so the lowest one wins
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!malloc_q[i]) free_idx = AW'(i);
  end
  // next allocation bitmap and count; a pop then push of the same slot leaves it allocated
  always_comb begin
    malloc_d = malloc_q;
    if (pop_ok) malloc_d[shift_buffer_pop_index] = 1'b0;
    if (push_ok) malloc_d[tgt] = 1'b1;
    malloc_d = flush ? '0 : malloc_d;
    count_d  = flush ? '0 : count_q + CW'(push_ok) - CW'(pop_ok);
  end
  // state registers; info is retained on flush and only written on an accepted push
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      malloc_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) info_q[i] <= '0;
    end else begin
      malloc_q <= malloc_d;
      count_q  <= count_d;
      if (push_ok && !flush) info_q[tgt] <= dispat_info;
    end
  end
  assign shift_buffer_malloc = malloc_q;
  assign buffer_count        = count_q;
  for (genvar g = 0; g < DEPTH; g++) begin : g_info
    assign shift_issue_info[DW*g +: DW] = info_q[g];
  end
endmodule

// File: doc/shift_issue_buffer.md
Name: shift_issue_buffer

Overview:
- Reservation buffer that holds decoded shift micro-ops between dispatch and the shift issue selector.
- Dispatch writes entries into free slots.
- The issue selector reads all entries in parallel through the malloc bitmap and the flattened info bus, then releases one slot per cycle by index.
- Flush clears the whole buffer on a branch mispredict or exception.

Parameters:
- DEPTH, 4, number of slots; power of two, 2..16.
- DW, 64, width of one entry's issue-info word (matches SHIFT_ISSUE_INFO_DW).

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- flush  input  1  discard all entries.
- dispat_push  input  1  dispatch offers one entry this cycle.
- dispat_info  input  DW  entry payload.
- buffer_full  output  1  no slot can accept a push this cycle.
- buffer_count  output  $clog2(DEPTH)+1  number of allocated slots.
- shift_buffer_pop  input  1  issue releases one slot.
- shift_buffer_pop_index  input  $clog2(DEPTH)  slot being released.
- shift_buffer_malloc  output  DEPTH  bit i set = slot i holds a valid entry.
- shift_issue_info  output  DW*DEPTH  slot i payload at [DW*i +: DW].

Behaviour:
- State:
  - malloc[DEPTH-1:0] flops.
  - info register array DEPTH x DW.
  - count register.
- Reset (RST high, asynchronous): malloc=0, all info=0, count=0. Outputs then read shift_buffer_malloc=0, shift_issue_info=0, buffer_full=0, buffer_count=0. Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Allocation:
  - Target slot = lowest index i with malloc[i]==0, computed from the current-cycle malloc (leading-zero priority).
  - On push accepted (dispat_push & ~buffer_full): info[target] <= dispat_info and malloc[target] <= 1 at the edge.
  - Entry is visible on the outputs one cycle after the push (1-cycle latency).
- Release: on shift_buffer_pop with malloc[idx]==1, malloc[idx] <= 0 at the edge. The info register is not cleared (its content is don't-care while malloc=0).
- Pop of an unallocated index: ignored; no state change. Verification flags this as a protocol error.
- Push while buffer_full: dropped, no state change; protocol error for dispatch. Dispatch stalls on buffer_full combinationally.
- Simultaneous push and pop (different slots): both take effect at the same edge; count unchanged.
- buffer_full = &malloc (without the optional feature).
- count:
  - +1 on accepted push alone.
  - -1 on valid pop alone.
  - unchanged when both or neither occur.
  - Must always equal popcount(malloc); verification asserts this.
- flush:
  - Dominates push and pop in the same cycle.
  - At the edge: malloc=0, count=0. Info registers are retained.
  - buffer_full still reflects the pre-flush malloc during the flush cycle.
- Wrap/boundary:
  - When DEPTH-1 slots are full, the single free slot is chosen regardless of its index.
  - Slots freed in any order are reused lowest-index-first.

Optional Feature:
- Macro SHIFT_BUFFER_POP_BYPASS_EN.
- Defined:
  - buffer_full = (&malloc) & ~(shift_buffer_pop & malloc[shift_buffer_pop_index]).
  - When all slots are full and a valid pop occurs, target slot = shift_buffer_pop_index.
  - At that edge the slot is rewritten with dispat_info and malloc stays 1; count is unchanged.
  - This gives zero-bubble throughput when the buffer is full.
- Undefined: a slot freed by a pop becomes allocatable only from the next cycle. Full-buffer push and pop in the same cycle yields pop only.

Test Plan:
1. Reset then push A,B,C,D on 4 consecutive cycles (DEPTH=4) -> malloc 0001,0011,0111,1111 on successive cycles; buffer_full=1 and buffer_count=4 after the 4th edge; info slots 0..3 = A..D.
2. Full buffer, pop index 2 -> malloc=1011 next cycle. Push E in the following cycle -> E lands in slot 2, malloc=1111.
3. malloc=0101, push F and pop index 0 in the same cycle -> F written to slot 1; malloc=0110; count stays 2.
4. malloc=1111, flush together with push G and pop 3 -> malloc=0000 and count=0 next cycle; G is not written.
5. Pop index 1 while malloc=0001 -> no change, protocol assertion fires. Assert RST mid-cycle with malloc=0111 -> outputs go to 0 before the next CLK edge.
6. With SHIFT_BUFFER_POP_BYPASS_EN: malloc=1111, pop index 1 and push H in the same cycle -> buffer_full=0 that cycle; slot 1 = H, malloc=1111 next cycle. Without the macro: push dropped, malloc=1101.
